// File: rtl/alu_dec_pkg.sv
// Shared constants for the ALU / decoder / counter cluster: datapath width
// and the 3-bit ALU opcode encodings.
package alu_dec_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU with zero, signed-overflow and carry flags.
// Carry and overflow are only meaningful for ADD and SUB and read as 0
// for every other opcode.
module alu4_core
  import alu_dec_pkg::*;
(
  input  logic [2:0]       fnSel,
  input  logic [ALU_W-1:0] opA,
  input  logic [ALU_W-1:0] opB,
  output logic [ALU_W-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             carry
);

  logic [ALU_W:0]   sumFull;
  logic [ALU_W:0]   diffFull;
  logic [ALU_W-1:0] sumRes;
  logic [ALU_W-1:0] diffRes;
  logic             sumOvf;
  logic             diffOvf;
  logic             lessThan;

  // Adder and subtractor are always evaluated; SLT reuses the subtractor so
  // the signed comparison needs no separate comparator.
  always_comb begin
    sumFull  = {1'b0, opA} + {1'b0, opB};
    diffFull = {1'b0, opA} + {1'b0, ~opB} + {{ALU_W{1'b0}}, 1'b1};
    sumRes   = sumFull[ALU_W-1:0];
    diffRes  = diffFull[ALU_W-1:0];
    sumOvf   = (opA[ALU_W-1] == opB[ALU_W-1]) & (sumRes[ALU_W-1] != opA[ALU_W-1]);
    diffOvf  = (opA[ALU_W-1] != opB[ALU_W-1]) & (diffRes[ALU_W-1] != opA[ALU_W-1]);
    lessThan = diffRes[ALU_W-1] ^ diffOvf;
  end

  // Opcode mux: result plus flags, defaults first so non-arithmetic ops
  // leave carry and overflow at zero.
  always_comb begin
    res      = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (fnSel)
      OP_ADD: begin
        res      = sumRes;
        overflow = sumOvf;
        carry    = sumFull[ALU_W];
      end
      OP_SUB: begin
        res      = diffRes;
        overflow = diffOvf;
        carry    = diffFull[ALU_W];
      end
      OP_NOT:  res = ~opA;
      OP_AND:  res = opA & opB;
      OP_OR:   res = opA | opB;
      OP_XOR:  res = opA ^ opB;
      OP_SLT:  res = {{(ALU_W-1){1'b0}}, lessThan};
      OP_EQ:   res = {{(ALU_W-1){1'b0}}, (opA == opB)};
      default: res = '0;
    endcase
    zero = ~|res;
  end

endmodule

// File: rtl/alu_dec_count_unit.sv
// Board-demo datapath cluster: combinational 4-bit ALU, 3-to-8 decoder
// with enable, and a tick-driven down counter, the only stateful element.
module alu_dec_count_unit
  import alu_dec_pkg::*;
#(
  parameter int                 CNT_W    = 3,
  parameter logic [CNT_W-1:0]   CNT_INIT = '0
)(
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       alu_fnselec,
  input  logic [ALU_W-1:0] alu_a,
  input  logic [ALU_W-1:0] alu_b,
  output logic [ALU_W-1:0] alu_res,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_carry,
  input  logic [2:0]       dec_x,
  input  logic             dec_en,
  output logic [7:0]       dec_y,
  input  logic             cnt_tick,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt_q
);

  logic [CNT_W-1:0] cnt_d;

  alu4_core u_alu (
    .fnSel    (alu_fnselec),
    .opA      (alu_a),
    .opB      (alu_b),
    .res      (alu_res),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .carry    (alu_carry)
  );

  // One-hot decode of the select, all zeros while disabled.
  always_comb begin
    dec_y = 8'h00;
    if (dec_en) begin
      dec_y = 8'h01 << dec_x;
    end
  end

  // Next count: level-sensitive tick, so a held tick decrements every cycle;
  // modulo arithmetic gives the wrap from 0 to all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_tick && cnt_en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; reset release is already synchronised upstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= CNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_dec_count_unit.sv
// Directed self-checking bench for alu_dec_count_unit.
module tb_alu_dec_count_unit;

  logic       clk;
  logic       resetn;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic [2:0] dec_x;
  logic       dec_en;
  logic [7:0] dec_y;
  logic       cnt_tick;
  logic       cnt_en;
  logic [2:0] cnt_q;

  int checks;
  int failures;

  alu_dec_count_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_fnselec  (alu_fnselec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .dec_x        (dec_x),
    .dec_en       (dec_en),
    .dec_y        (dec_y),
    .cnt_tick     (cnt_tick),
    .cnt_en       (cnt_en),
    .cnt_q        (cnt_q)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if (cnt_q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_value: got %0d expected 0", cnt_q);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got %0d expected 0", cnt_q);
    end
  endtask

  // Expected packed as {res, zero, ovf, carry}.
  task automatic test_add_sub();
    logic [2:0] op   [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
    logic [3:0] va   [5] = '{4'b0111, 4'b1111, 4'b0000, 4'b0101, 4'b1000};
    logic [3:0] vb   [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
    logic [6:0] expV [5] = '{{4'b1000, 3'b010}, {4'b0000, 3'b101},
                             {4'b1111, 3'b000}, {4'b0000, 3'b101},
                             {4'b0111, 3'b011}};
    for (int i = 0; i < 5; i++) begin
      alu_fnselec = op[i];
      alu_a       = va[i];
      alu_b       = vb[i];
      #1;
      checks++;
      if ({alu_res, alu_zero, alu_overflow, alu_carry} !== expV[i]) begin
        failures++;
        $display("[TB] FAIL add_sub[%0d] op=%b a=%b b=%b: got res=%b z=%b v=%b c=%b expected %b",
                 i, op[i], va[i], vb[i], alu_res, alu_zero, alu_overflow, alu_carry, expV[i]);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0] op   [9] = '{3'b110, 3'b110, 3'b111, 3'b010, 3'b011,
                             3'b100, 3'b101, 3'b101, 3'b011};
    logic [3:0] va   [9] = '{4'b1000, 4'b0011, 4'b1010, 4'b0101, 4'b1100,
                             4'b1100, 4'b1100, 4'b0101, 4'b1111};
    logic [3:0] vb   [9] = '{4'b0001, 4'b0011, 4'b1010, 4'b0000, 4'b1010,
                             4'b1010, 4'b1010, 4'b0101, 4'b1111};
    logic [6:0] expV [9] = '{{4'b0001, 3'b000}, {4'b0000, 3'b100},
                             {4'b0001, 3'b000}, {4'b1010, 3'b000},
                             {4'b1000, 3'b000}, {4'b1110, 3'b000},
                             {4'b0110, 3'b000}, {4'b0000, 3'b100},
                             {4'b1111, 3'b000}};
    for (int i = 0; i < 9; i++) begin
      alu_fnselec = op[i];
      alu_a       = va[i];
      alu_b       = vb[i];
      #1;
      checks++;
      if ({alu_res, alu_zero, alu_overflow, alu_carry} !== expV[i]) begin
        failures++;
        $display("[TB] FAIL logic_ops[%0d] op=%b a=%b b=%b: got res=%b z=%b v=%b c=%b expected %b",
                 i, op[i], va[i], vb[i], alu_res, alu_zero, alu_overflow, alu_carry, expV[i]);
      end
    end
  endtask

  task automatic test_decoder();
    logic [7:0] expY [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) begin
      dec_en = 1'b1;
      dec_x  = 3'(i);
      #1;
      checks++;
      if (dec_y !== expY[i]) begin
        failures++;
        $display("[TB] FAIL decoder_en x=%0d: got %h expected %h", i, dec_y, expY[i]);
      end
      dec_en = 1'b0;
      #1;
      checks++;
      if (dec_y !== 8'h00) begin
        failures++;
        $display("[TB] FAIL decoder_dis x=%0d: got %h expected 00", i, dec_y);
      end
    end
  endtask

  task automatic test_count_down();
    logic [2:0] expC [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cnt_tick = 1'b1;
      @(posedge clk);
      #1;
      cnt_tick = 1'b0;
      checks++;
      if (cnt_q !== expC[i]) begin
        failures++;
        $display("[TB] FAIL count_down step %0d: got %0d expected %0d", i, cnt_q, expC[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (cnt_q !== expC[i]) begin
        failures++;
        $display("[TB] FAIL count_idle step %0d: got %0d expected %0d", i, cnt_q, expC[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    cnt_en   = 1'b0;
    cnt_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd7) begin
      failures++;
      $display("[TB] FAIL hold_en_low: got %0d expected 7", cnt_q);
    end
    cnt_tick = 1'b0;
    cnt_en   = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] expC [3] = '{3'd6, 3'd5, 3'd4};
    @(negedge clk);
    cnt_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) cnt_tick = 1'b0;
      checks++;
      if (cnt_q !== expC[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d]: got %0d expected %0d", i, cnt_q, expC[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd4) begin
      failures++;
      $display("[TB] FAIL back_to_back_after: got %0d expected 4", cnt_q);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    cnt_tick = 1'b1;
    cnt_en   = 1'b1;
    resetn   = 1'b0;
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got %0d expected 0", cnt_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_held: got %0d expected 0", cnt_q);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cnt_tick = 1'b0;
    checks++;
    if (cnt_q !== 3'd7) begin
      failures++;
      $display("[TB] FAIL tick_after_release: got %0d expected 7", cnt_q);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks      = 0;
    failures    = 0;
    resetn      = 1'b0;
    alu_fnselec = 3'b000;
    alu_a       = 4'b0000;
    alu_b       = 4'b0000;
    dec_x       = 3'b000;
    dec_en      = 1'b0;
    cnt_tick    = 1'b0;
    cnt_en      = 1'b0;
    test_reset();
    test_add_sub();
    test_logic_ops();
    test_decoder();
    test_count_down();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
